seq_pattern_gen: RTL and testbench

Serial pattern transmitter: the sending end of the single-bit serial line whose receive side is the team's Moore sequence detector. The block captures a pattern of up to WIDTH bits, a length and a repeat count, then shifts the pattern out MSB-first, one bit per bit_en strobe. Frames are separated by idle-high gap bits. It drives detector stimulus in the lab top level and the loopback checks.

---
 rtl/seq_gen_pkg.sv | 19 +
 rtl/seq_shift_reg.sv | 32 +++
 rtl/seq_pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Level driven on the serial line whenever no pattern bit is being sent.
  localparam logic IDLE_LVL = 1'b1;

  // Limit a requested pattern length to the register width.
  function automatic logic [31:0] clamp_len(input logic [31:0] len,
                                            input logic [31:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Left-aligned load/shift register. Load wins over shift. The MSB exposed is
// the value the register will hold after the current edge, so the parent can
// register its serial output in the same cycle as the register update.
module seq_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             msb_next_o
);

  logic [WIDTH-1:0] sh_q, sh_d;

  // Next contents: load, shift left by one, or hold.
  always_comb begin
    sh_d = sh_q;
    if (load)       sh_d = load_data;
    else if (shift) sh_d = {sh_q[WIDTH-2:0], 1'b0};
  end

  assign msb_next_o = sh_d[WIDTH-1];

  // Register with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) sh_q <= '0;
    else       sh_q <= sh_d;
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends pat_data MSB-first, one bit per bit_en
// strobe, repeated rep_cnt times with GAP idle-high bits between frames.
//
// Handshake: start is a request sampled only while busy=0 (state IDLE); it is
// accepted in that cycle, including the cycle done is high. While busy=1,
// start and the pattern inputs are ignored and the captured copy is used.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int GAP   = 2,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_en,
  input  logic [WIDTH-1:0] pat_data,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] rep_cnt,
  output logic             x_out,
  output logic             busy,
  output logic             done,
  output logic             frame_start,
  output state_e           state_dbg
);

  localparam int GAP_CW   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
  logic             done_q, done_d;
  logic             fs_q, fs_d;
  logic             x_out_q, x_out_d;

  logic             sh_load, sh_shift, sh_msb_next;
  logic [WIDTH-1:0] sh_data;
  logic [LEN_W-1:0] len_c;
  logic [WIDTH-1:0] aligned_c;

  assign len_c     = LEN_W'(clamp_len(32'(pat_len), 32'(WIDTH)));
  assign aligned_c = pat_data << (WIDTH - int'(len_c));

  seq_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clock      (clock),
    .reset      (reset),
    .load       (sh_load),
    .load_data  (sh_data),
    .shift      (sh_shift),
    .msb_next_o (sh_msb_next)
  );

  // Next-state, counters, shadow capture and shift-register control.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pat_d     = pat_q;
    frames_d  = frames_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    fs_d      = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_data   = pat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_c == '0) begin
            done_d = 1'b1;
          end else begin
            len_d     = len_c;
            pat_d     = aligned_c;
            frames_d  = (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            sh_load   = 1'b1;
            sh_data   = aligned_c;
            fs_d      = 1'b1;
            state_d   = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (bit_en) begin
          sh_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + LEN_W'(1);
          if (bit_cnt_q == len_q - LEN_W'(1)) begin
            bit_cnt_d = '0;
            if (frames_q > CNT_W'(1)) begin
              if (GAP == 0) begin
                sh_load  = 1'b1;
                frames_d = frames_q - CNT_W'(1);
                fs_d     = 1'b1;
              end else begin
                gap_cnt_d = '0;
                state_d   = ST_GAP;
              end
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        if (bit_en) begin
          if (gap_cnt_q == GAP_CW'(GAP_LAST)) begin
            gap_cnt_d = '0;
            sh_load   = 1'b1;
            frames_d  = frames_q - CNT_W'(1);
            fs_d      = 1'b1;
            state_d   = ST_SEND;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    x_out_d = (state_d == ST_SEND) ? sh_msb_next : IDLE_LVL;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      pat_q     <= '0;
      frames_q  <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
      fs_q      <= 1'b0;
      x_out_q   <= IDLE_LVL;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      pat_q     <= pat_d;
      frames_q  <= frames_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
      fs_q      <= fs_d;
      x_out_q   <= x_out_d;
    end
  end

  assign x_out       = x_out_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign frame_start = fs_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen with WIDTH=8, CNT_W=4, GAP=2.
module tb_seq_pattern_gen;
  import seq_gen_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       bit_en;
  logic [7:0] pat_data;
  logic [3:0] pat_len;
  logic [3:0] rep_cnt;
  logic       x_out, busy, done, frame_start;
  state_e     state_dbg;

  int checks   = 0;
  int failures = 0;

  seq_pattern_gen #(.WIDTH(8), .CNT_W(4), .GAP(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .bit_en      (bit_en),
    .pat_data    (pat_data),
    .pat_len     (pat_len),
    .rep_cnt     (rep_cnt),
    .x_out       (x_out),
    .busy        (busy),
    .done        (done),
    .frame_start (frame_start),
    .state_dbg   (state_dbg)
  );

  // Clock
  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic       be;
    logic [7:0] data;
    logic [3:0] len;
    logic [3:0] rep;
    logic       ex;
    logic       eb;
    logic       ed;
    logic       efs;
  } vec_t;

  vec_t vecs[17];

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int k, input logic ex,
                            input logic eb, input logic ed, input logic efs);
    check_bit($sformatf("%s c%0d x_out", tag, k), x_out, ex);
    check_bit($sformatf("%s c%0d busy", tag, k), busy, eb);
    check_bit($sformatf("%s c%0d done", tag, k), done, ed);
    check_bit($sformatf("%s c%0d frame_start", tag, k), frame_start, efs);
  endtask

  task automatic drive(input logic st, input logic be, input logic [7:0] d,
                       input logic [3:0] l, input logic [3:0] r);
    start    = st;
    bit_en   = be;
    pat_data = d;
    pat_len  = l;
    rep_cnt  = r;
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  initial begin
    logic [3:0] slow_bits;
    logic [7:0] clamp_pat;

    // Vector table: inputs for the cycle, outputs expected in that cycle.
    vecs[0]  = '{1'b1, 1'b1, 8'h07, 4'd4, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    // done cycle of first frame; back-to-back start of a 2-frame pattern "01"
    vecs[5]  = '{1'b1, 1'b1, 8'h01, 4'd2, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    // done; start a 1-bit frame (bit 0 of FE = 0) with rep_cnt=0 -> one frame
    vecs[12] = '{1'b1, 1'b1, 8'hFE, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    // done; start with zero length
    vecs[14] = '{1'b1, 1'b0, 8'hFF, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);
    repeat (3) next_cycle();
    reset = 1'b0;
    check_outs("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL reset state: got %0d expected %0d", state_dbg, ST_IDLE);
    end

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      check_outs("table", i, vecs[i].ex, vecs[i].eb, vecs[i].ed, vecs[i].efs);
      drive(vecs[i].st, vecs[i].be, vecs[i].data, vecs[i].len, vecs[i].rep);
      next_cycle();
    end

    // Slow strobe: bit_en every 3rd cycle, start coincides with a strobe.
    slow_bits = 4'b0111;
    for (int k = 0; k <= 14; k++) begin
      if (k >= 1 && k <= 12)
        check_outs("slow", k, slow_bits[3 - (k - 1) / 3], 1'b1, 1'b0, k == 1);
      else if (k == 13)
        check_outs("slow", k, 1'b1, 1'b0, 1'b1, 1'b0);
      else
        check_outs("slow", k, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(k == 0, (k % 3) == 0, 8'h07, 4'd4, 4'd1);
      next_cycle();
    end

    // Clamp: pat_len=12 sends all 8 bits.
    clamp_pat = 8'hA5;
    for (int k = 0; k <= 10; k++) begin
      if (k >= 1 && k <= 8)
        check_outs("clamp", k, clamp_pat[8 - k], 1'b1, 1'b0, k == 1);
      else if (k == 9)
        check_outs("clamp", k, 1'b1, 1'b0, 1'b1, 1'b0);
      else
        check_outs("clamp", k, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(k == 0, 1'b1, 8'hA5, 4'd12, 4'd1);
      next_cycle();
    end

    // Abort: reset during bit 2 (cycle 3); no done afterwards.
    for (int k = 0; k <= 8; k++) begin
      if (k == 1)      check_outs("abort", k, 1'b0, 1'b1, 1'b0, 1'b1);
      else if (k <= 3 && k >= 2) check_outs("abort", k, 1'b1, 1'b1, 1'b0, 1'b0);
      else             check_outs("abort", k, 1'b1, 1'b0, 1'b0, 1'b0);
      reset = (k == 3);
      drive(k == 0, 1'b1, 8'h07, 4'd4, 4'd1);
      next_cycle();
    end
    reset = 1'b0;

    // Start while busy with a different pattern is ignored.
    for (int k = 0; k <= 7; k++) begin
      if (k == 1)                check_outs("busy_start", k, 1'b0, 1'b1, 1'b0, 1'b1);
      else if (k >= 2 && k <= 4) check_outs("busy_start", k, 1'b1, 1'b1, 1'b0, 1'b0);
      else if (k == 5)           check_outs("busy_start", k, 1'b1, 1'b0, 1'b1, 1'b0);
      else                       check_outs("busy_start", k, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k == 0)      drive(1'b1, 1'b1, 8'h07, 4'd4, 4'd1);
      else if (k == 2) drive(1'b1, 1'b1, 8'h0F, 4'd8, 4'd3);
      else             drive(1'b0, 1'b1, 8'h0F, 4'd8, 4'd3);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
